// File: rtl/adc_bcd_display_driver_if.sv
// Sample/strobe input and display-pattern output bundle between the ADC front end
// and the seven-segment multiplexer.
interface adc_bcd_display_driver_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              busy;
  logic              done;
  logic [6:0]        seg_a;
  logic [6:0]        seg_b;
  logic [6:0]        seg_c;
  logic [6:0]        seg_d;
  logic [1:0]        sel;

  modport master (
    output data_in, data_valid,
    input  busy, done, seg_a, seg_b, seg_c, seg_d, sel
  );

  modport slave (
    input  data_in, data_valid,
    output busy, done, seg_a, seg_b, seg_c, seg_d, sel
  );
endinterface

// File: rtl/adc_bcd_display_driver.sv
// Captures an ADC sample, converts it to 3 BCD digits by sequential double-dabble,
// and holds leading-zero-blanked active-low segment patterns plus a mux digit-select.
module adc_bcd_display_driver #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned REFRESH_BITS = 16
) (
  input logic                      clk,
  input logic                      reset,
  adc_bcd_display_driver_if.slave  bus
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned SR_W  = BCD_W + DATA_W;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [6:0] BLANK  = 7'b1111111;
  localparam logic [6:0] DIGIT0 = 7'b1000000;

  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

  state_t                  state, state_nxt;
  logic [SR_W-1:0]         sr, sr_nxt, adj;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [6:0]              seg_a_r, seg_b_r, seg_c_r;
  logic [6:0]              seg_a_nxt, seg_b_nxt, seg_c_nxt;
  logic                    done_r, done_nxt;
  logic [REFRESH_BITS-1:0] refresh;
  logic [3:0]              units, tens, hundreds;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = BLANK;
    endcase
  endfunction

  assign units    = sr[DATA_W   +: 4];
  assign tens     = sr[DATA_W+4 +: 4];
  assign hundreds = sr[DATA_W+8 +: 4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      seg_a_r <= DIGIT0;
      seg_b_r <= BLANK;
      seg_c_r <= BLANK;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      seg_a_r <= seg_a_nxt;
      seg_b_r <= seg_b_nxt;
      seg_c_r <= seg_c_nxt;
      done_r  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    seg_a_nxt = seg_a_r;
    seg_b_nxt = seg_b_r;
    seg_c_nxt = seg_c_r;
    done_nxt  = 1'b0;
    adj       = sr;
    case (state)
      IDLE: begin
        if (bus.data_valid) begin
          sr_nxt    = {{BCD_W{1'b0}}, bus.data_in};
          cnt_nxt   = '0;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        // Correct every BCD nibble before the shift so it carries as decimal.
        for (int unsigned i = 0; i < 3; i++) begin
          if (sr[DATA_W+4*i +: 4] >= 4'd5)
            adj[DATA_W+4*i +: 4] = sr[DATA_W+4*i +: 4] + 4'd3;
        end
        sr_nxt  = {adj[SR_W-2:0], 1'b0};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W-1))
          state_nxt = LATCH;
      end
      LATCH: begin
        seg_a_nxt = encode(units);
        seg_b_nxt = (hundreds == 4'd0 && tens == 4'd0) ? BLANK : encode(tens);
        seg_c_nxt = (hundreds == 4'd0) ? BLANK : encode(hundreds);
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) refresh <= '0;
    else       refresh <= refresh + REFRESH_BITS'(1);
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_r;
  assign bus.seg_a = seg_a_r;
  assign bus.seg_b = seg_b_r;
  assign bus.seg_c = seg_c_r;
  assign bus.seg_d = BLANK;
  assign bus.sel   = refresh[REFRESH_BITS-1 -: 2];

endmodule
